ram_port_arbiter: RTL and testbench

Two-master arbiter sharing the single data port of the 64 KB dual-port RAM. Master 0 is the CPU data-side adapter; master 1 is a loader/DMA master such as a UART bootloader. The block round-robins between the masters, allows one outstanding access, and routes each response to the master that issued it. Addresses outside the RAM window are rejected with an error response and never reach the RAM.

---
 rtl/ram_port_arbiter_if.sv | 23 ++
 rtl/ram_port_arbiter.sv | 91 +++++++++
 tb/tb_ram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// One master channel of the shared RAM data port: request payload with
// valid/ready, plus a single-cycle response (rvalid/rdata/err).
interface ram_port_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, we, wstrb, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, we, wstrb, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter giving two masters one-outstanding access to a single
// RAM data port; out-of-window addresses get an error response instead.
module ram_port_arbiter #(
  parameter logic [31:0] RAM_BYTES  = 32'd65536,
  parameter bit          RESET_LAST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    m0,
  ram_port_arbiter_if.slave    m1,
  output logic                 ram_re,
  output logic                 ram_we,
  output logic [3:0]           ram_wstrb,
  output logic [31:0]          ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic        last_grant;   // index of the master granted most recently
  logic        owner;        // master whose response is pending in RESP
  logic        rsp_read;     // pending response carries RAM read data
  logic        rsp_err;      // pending response is an out-of-range error

  logic        grant1;
  logic        issue;
  logic        in_range;
  logic        ram_strobe;
  logic        rsp_active;
  logic        sel_we;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // NOTE: every signal gets an unconditional value on each pass so no latch is inferred.
  always_comb begin
    grant1     = m1.valid & (~m0.valid | ~last_grant);
    issue      = ~rst & (state == IDLE) & (m0.valid | m1.valid);
    sel_we     = grant1 ? m1.we    : m0.we;
    sel_wstrb  = grant1 ? m1.wstrb : m0.wstrb;
    sel_addr   = grant1 ? m1.addr  : m0.addr;
    sel_wdata  = grant1 ? m1.wdata : m0.wdata;
    in_range   = sel_addr < RAM_BYTES;
    ram_strobe = issue & in_range;
    ram_re     = ram_strobe & ~sel_we;
    ram_we     = ram_strobe & sel_we;
    ram_wstrb  = ram_strobe ? sel_wstrb : 4'b0000;
    ram_addr   = ram_strobe ? sel_addr  : 32'd0;
    ram_wdata  = ram_strobe ? sel_wdata : 32'd0;
  end

  assign m0.ready = issue & ~grant1;
  assign m1.ready = issue & grant1;

  // Reset is gated in so a response in flight when rst rises is dropped at once.
  assign rsp_active = ~rst & (state == RESP);
  assign m0.rvalid  = rsp_active & ~owner;
  assign m1.rvalid  = rsp_active & owner;
  assign m0.err     = m0.rvalid & rsp_err;
  assign m1.err     = m1.rvalid & rsp_err;
  assign m0.rdata   = (m0.rvalid & rsp_read) ? ram_rdata : 32'd0;
  assign m1.rdata   = (m1.rvalid & rsp_read) ? ram_rdata : 32'd0;

  // NOTE: non-blocking assignments keep every register update in this block concurrent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= RESET_LAST;
      owner      <= 1'b0;
      rsp_read   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            owner      <= grant1;
            last_grant <= grant1;
            rsp_read   <= in_range & ~sel_we;
            rsp_err    <= ~in_range;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM on the data port;
// expected values are hand-computed per step.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ram_re;
  logic        ram_we;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        pre_we;
  logic [13:0] pre_idx;
  logic [31:0] pre_data;
  logic [31:0] mem [0:16383];

  int n_checks;
  int n_pass;

  ram_port_arbiter_if m0_bus ();
  ram_port_arbiter_if m1_bus ();

  ram_port_arbiter #(
    .RAM_BYTES  (32'd65536),
    .RESET_LAST (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_wstrb (ram_wstrb),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: byte-lane writes, one-cycle read latency, bench preload port.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_wstrb[i]) mem[ram_addr[15:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    if (ram_re) ram_rdata <= mem[ram_addr[15:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  task automatic set_m0(input logic v, input logic we, input logic [3:0] ws,
                        input logic [31:0] a, input logic [31:0] wd);
    m0_bus.valid = v;
    m0_bus.we    = we;
    m0_bus.wstrb = ws;
    m0_bus.addr  = a;
    m0_bus.wdata = wd;
  endtask

  task automatic set_m1(input logic v, input logic we, input logic [3:0] ws,
                        input logic [31:0] a, input logic [31:0] wd);
    m1_bus.valid = v;
    m1_bus.we    = we;
    m1_bus.wstrb = ws;
    m1_bus.addr  = a;
    m1_bus.wdata = wd;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    pre_we    = 1'b0;
    pre_idx   = '0;
    pre_data  = '0;
    ram_rdata = '0;
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    preload(14'h0004, 32'hDEADBEEF);   // byte 0x0010
    preload(14'h0008, 32'h11223344);   // byte 0x0020
    preload(14'h0000, 32'h00001111);   // byte 0x0000
    preload(14'h0001, 32'h00004444);   // byte 0x0004
    preload(14'h3FFF, 32'hCAFEF00D);   // byte 0xFFFC

    // Reset held with both masters requesting: every output stays 0.
    set_m0(1, 0, 4'h0, 32'h10, 32'h0);
    set_m1(1, 1, 4'hF, 32'h20, 32'hFFFFFFFF);
    #1;
    check("rst_m0_ready", m0_bus.ready, 0);
    check("rst_m1_ready", m1_bus.ready, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_ram_wstrb", ram_wstrb, 0);
    check("rst_m0_rvalid", m0_bus.rvalid, 0);
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Single read by m0.
    set_m0(1, 0, 4'h0, 32'h10, 32'h0);
    #1;
    check("rd_m0_ready", m0_bus.ready, 1);
    check("rd_m1_ready", m1_bus.ready, 0);
    check("rd_ram_re", ram_re, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, 32'h10);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rd_m0_rvalid", m0_bus.rvalid, 1);
    check("rd_m0_rdata", m0_bus.rdata, 32'hDEADBEEF);
    check("rd_m0_err", m0_bus.err, 0);
    check("rd_m1_rvalid", m1_bus.rvalid, 0);
    check("rd_resp_ready", m0_bus.ready, 0);
    next_cycle();
    #1;
    check("idle_m0_rvalid", m0_bus.rvalid, 0);
    check("idle_ram_re", ram_re, 0);
    check("idle_ram_addr", ram_addr, 0);

    // Byte-lane write by m1, then read back.
    set_m1(1, 1, 4'b0010, 32'h20, 32'h0000AB00);
    #1;
    check("wr_m1_ready", m1_bus.ready, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_re", ram_re, 0);
    check("wr_ram_wstrb", ram_wstrb, 4'b0010);
    check("wr_ram_wdata", ram_wdata, 32'h0000AB00);
    check("wr_ram_addr", ram_addr, 32'h20);
    next_cycle();
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("wr_m1_rvalid", m1_bus.rvalid, 1);
    check("wr_m1_err", m1_bus.err, 0);
    check("wr_m1_rdata", m1_bus.rdata, 0);
    check("wr_m0_rvalid", m0_bus.rvalid, 0);
    next_cycle();
    set_m1(1, 0, 4'h0, 32'h20, 32'h0);
    #1;
    check("rb_m1_ready", m1_bus.ready, 1);
    next_cycle();
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rb_m1_rdata", m1_bus.rdata, 32'h1122AB44);

    // Out-of-range requests and the window boundary.
    next_cycle();
    set_m0(1, 0, 4'h0, 32'h1000_0000, 32'h0);
    #1;
    check("oor_m0_ready", m0_bus.ready, 1);
    check("oor_ram_re", ram_re, 0);
    check("oor_ram_we", ram_we, 0);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("oor_m0_rvalid", m0_bus.rvalid, 1);
    check("oor_m0_err", m0_bus.err, 1);
    check("oor_m0_rdata", m0_bus.rdata, 0);
    next_cycle();
    set_m0(1, 0, 4'h0, 32'h0001_0000, 32'h0);
    #1;
    check("edge_top_ram_re", ram_re, 0);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("edge_top_err", m0_bus.err, 1);
    next_cycle();
    set_m0(1, 0, 4'h0, 32'h0000_FFFF, 32'h0);
    #1;
    check("edge_last_ram_re", ram_re, 1);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("edge_last_err", m0_bus.err, 0);
    next_cycle();
    set_m0(1, 0, 4'h0, 32'h0000_FFFC, 32'h0);
    #1;
    check("fffc_ram_re", ram_re, 1);
    check("fffc_ram_addr", ram_addr, 32'h0000_FFFC);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("fffc_m0_rdata", m0_bus.rdata, 32'hCAFEF00D);
    check("fffc_m0_err", m0_bus.err, 0);

    // Contention right after reset (last grant before reset was m0).
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_m0(1, 0, 4'h0, 32'h0, 32'h0);
    set_m1(1, 0, 4'h0, 32'h4, 32'h0);
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr%0d_m0_ready", c), m0_bus.ready, (c == 0 || c == 4) ? 1 : 0);
      check($sformatf("rr%0d_m1_ready", c), m1_bus.ready, (c == 2 || c == 6) ? 1 : 0);
      check($sformatf("rr%0d_m0_rdata", c), m0_bus.rdata,
            (c == 1 || c == 5) ? 32'h00001111 : 32'h0);
      check($sformatf("rr%0d_m1_rdata", c), m1_bus.rdata,
            (c == 3 || c == 7) ? 32'h00004444 : 32'h0);
      check($sformatf("rr%0d_m1_rvalid", c), m1_bus.rvalid, (c == 3 || c == 7) ? 1 : 0);
      next_cycle();
    end
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);

    // Reset asserted while m1's response is pending.
    set_m1(1, 0, 4'h0, 32'h10, 32'h0);
    #1;
    check("rmid_m1_ready", m1_bus.ready, 1);
    next_cycle();
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("rmid_m1_rvalid", m1_bus.rvalid, 0);
    check("rmid_m1_rdata", m1_bus.rdata, 0);
    check("rmid_m1_err", m1_bus.err, 0);
    check("rmid_m0_rvalid", m0_bus.rvalid, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rmid_after_m1_rvalid", m1_bus.rvalid, 0);
    set_m0(1, 0, 4'h0, 32'h10, 32'h0);
    set_m1(1, 0, 4'h0, 32'h20, 32'h0);
    #1;
    check("tie_m0_ready", m0_bus.ready, 1);
    check("tie_m1_ready", m1_bus.ready, 0);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("tie_m0_rdata", m0_bus.rdata, 32'hDEADBEEF);
    check("tie_resp_m1_ready", m1_bus.ready, 0);
    next_cycle();
    #1;
    check("tie2_m1_ready", m1_bus.ready, 1);
    next_cycle();
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("tie2_m1_rdata", m1_bus.rdata, 32'h1122AB44);

    // m1 waits while m0 (zero-strobe write) is mid-transaction.
    next_cycle();
    set_m0(1, 1, 4'b0000, 32'h10, 32'hFFFFFFFF);
    #1;
    check("hold_m0_ready", m0_bus.ready, 1);
    check("hold_ram_we", ram_we, 1);
    check("hold_ram_wstrb", ram_wstrb, 4'b0000);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(1, 1, 4'b0001, 32'h0, 32'h000000AA);
    #1;
    check("hold_m0_rvalid", m0_bus.rvalid, 1);
    check("hold_m0_err", m0_bus.err, 0);
    check("hold_resp_m1_ready", m1_bus.ready, 0);
    next_cycle();
    #1;
    check("hold_m1_ready", m1_bus.ready, 1);
    check("hold_m1_ram_we", ram_we, 1);
    next_cycle();
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("hold_dup_m1_ready", m1_bus.ready, 0);
    check("hold_m1_rvalid", m1_bus.rvalid, 1);
    next_cycle();
    #1;
    check("hold_end_m1_rvalid", m1_bus.rvalid, 0);
    set_m0(1, 0, 4'h0, 32'h10, 32'h0);
    next_cycle();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("zstrb_unchanged", m0_bus.rdata, 32'hDEADBEEF);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
